// File: rtl/uart_tx_fifo_pkg.sv
// ============================================================
// Package : uart_tx_fifo_pkg
// Shared ASCII codes and transmit FSM encoding for uart_tx_fifo.
// Revision: 1.0
// ============================================================
`default_nettype none

package uart_tx_fifo_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      SETTLE = 2'd2
   } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================
// Module : byte_fifo
// Circular byte buffer with occupancy counter and combinational head read.
// Revision: 1.0
// ============================================================
`default_nettype none

module byte_fifo #(
   parameter int ADDR_BITS = 4
) (
   input  logic                 mclk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [7:0]           push_data,
   input  logic                 pop,
   output logic [7:0]           head,
   output logic [ADDR_BITS:0]   count,
   output logic                 full,
   output logic                 empty
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);

   logic [7:0]           mem [DEPTH];
   logic [ADDR_BITS-1:0] wr_ptr;
   logic [ADDR_BITS-1:0] rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   // Full is taken from the registered count, so a pop never frees a slot in the same cycle.
   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge mclk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================
// Module : uart_tx_fifo
// Byte FIFO and issue pacing in front of uart_tx; UART_TX_FIFO_CRLF_EN expands LF to CR,LF.
// Revision: 1.0
// ============================================================
`default_nettype none

module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int ADDR_BITS = 4
) (
   input  logic                 mclk,
   input  logic                 reset,
   input  logic [7:0]           in_data,
   input  logic                 in_strobe,
   output logic                 in_ready,
   output logic                 overflow,
   output logic [ADDR_BITS:0]   count,
   output logic [7:0]           tx_data,
   output logic                 tx_strobe,
   input  logic                 tx_ready
);

   tx_state_t  state;
   tx_state_t  state_next;
   logic       issue;
   logic       pop;
   logic [7:0] load_byte;
   logic [7:0] head;
   logic       full;
   logic       empty;

   assign in_ready = !full;

   byte_fifo #(
      .ADDR_BITS (ADDR_BITS)
   ) u_fifo (
      .mclk      (mclk),
      .reset     (reset),
      .push      (in_strobe),
      .push_data (in_data),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

`ifdef UART_TX_FIFO_CRLF_EN
   logic cr_sent;
   logic insert_cr;

   assign insert_cr = (head == ASCII_LF) && !cr_sent;

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         cr_sent <= 1'b0;
      end else if (issue) begin
         cr_sent <= insert_cr;
      end
   end
`endif

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // tx_ready is only sampled in IDLE; SEND/SETTLE cover the cycle uart_tx needs to drop it.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      pop        = 1'b0;
      load_byte  = head;
      case (state)
         IDLE: begin
            if (tx_ready && !empty) begin
               issue      = 1'b1;
               state_next = SEND;
`ifdef UART_TX_FIFO_CRLF_EN
               if (insert_cr) begin
                  load_byte = ASCII_CR;
               end else begin
                  pop = 1'b1;
               end
`else
               pop = 1'b1;
`endif
            end
         end
         SEND:    state_next = SETTLE;
         SETTLE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         tx_data   <= 8'h00;
         tx_strobe <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         tx_strobe <= issue;
         if (issue) begin
            tx_data <= load_byte;
         end
         if (in_strobe && !in_ready) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================
// Module : tb_uart_tx_fifo
// Directed self-checking bench with a behavioural uart_tx busy model capturing issued bytes.
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_uart_tx_fifo;

   localparam int ADDR_BITS = 4;
   localparam int BUSY      = 20;

   logic                mclk;
   logic                reset;
   logic [7:0]          in_data;
   logic                in_strobe;
   logic                in_ready;
   logic                overflow;
   logic [ADDR_BITS:0]  count;
   logic [7:0]          tx_data;
   logic                tx_strobe;
   logic                tx_ready;

   logic                ready_en;
   int                  busy;
   logic [7:0]          rx_q[$];
   int                  n_checks;
   int                  n_fail;

   uart_tx_fifo #(.ADDR_BITS(ADDR_BITS)) dut (
      .mclk      (mclk),
      .reset     (reset),
      .in_data   (in_data),
      .in_strobe (in_strobe),
      .in_ready  (in_ready),
      .overflow  (overflow),
      .count     (count),
      .tx_data   (tx_data),
      .tx_strobe (tx_strobe),
      .tx_ready  (tx_ready)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Transmitter stand-in: drops ready the cycle after a strobe and stays busy for BUSY cycles.
   assign tx_ready = ready_en && (busy == 0);

   always @(posedge mclk or posedge reset) begin
      if (reset) begin
         busy <= 0;
      end else if (tx_strobe) begin
         busy <= BUSY;
         rx_q.push_back(tx_data);
      end else if (busy != 0) begin
         busy <= busy - 1;
      end
   end

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic wait_rx(input int n, input int budget, output bit ok);
      int t;
      t = 0;
      while (rx_q.size() < n && t < budget) begin
         tick();
         t++;
      end
      ok = (rx_q.size() >= n);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      n_checks++;
      if ({in_ready, overflow, count, tx_data, tx_strobe} !== {1'b1, 1'b0, 5'd0, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_values: got ready=%b ovf=%b cnt=%0d data=%h stb=%b, want 1 0 0 00 0",
                  in_ready, overflow, count, tx_data, tx_strobe);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_abc();
      int base;
      bit ok;
      logic [7:0] exp [3];
      exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
      base = rx_q.size();
      ready_en = 1'b1;
      in_strobe = 1'b1; in_data = 8'h41;
      tick();
      n_checks++;
      if (tx_strobe !== 1'b0 || count !== 5'd1) begin
         n_fail++;
         $display("FAIL abc_cycle1: got stb=%b cnt=%0d, want stb=0 cnt=1", tx_strobe, count);
      end
      in_data = 8'h42;
      tick();
      n_checks++;
      if (tx_strobe !== 1'b1 || tx_data !== 8'h41) begin
         n_fail++;
         $display("FAIL abc_latency: got stb=%b data=%h, want stb=1 data=41", tx_strobe, tx_data);
      end
      in_data = 8'h43;
      tick();
      in_strobe = 1'b0;
      wait_rx(base + 3, 400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL abc_timeout: got %0d bytes, want 3", rx_q.size() - base);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rx_q.size() <= base + i || rx_q[base + i] !== exp[i]) begin
            n_fail++;
            $display("FAIL abc_byte%0d: got %h, want %h", i,
                     (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx, exp[i]);
         end
      end
      repeat (40) tick();
      n_checks++;
      if (rx_q.size() - base !== 3 || count !== 5'd0) begin
         n_fail++;
         $display("FAIL abc_final: got strobes=%0d cnt=%0d, want 3 0", rx_q.size() - base, count);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      ready_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         in_strobe = 1'b1; in_data = 8'(8'h10 + i);
         tick();
      end
      n_checks++;
      if (in_ready !== 1'b0 || overflow !== 1'b0 || count !== 5'd16) begin
         n_fail++;
         $display("FAIL ovf_full: got ready=%b ovf=%b cnt=%0d, want 0 0 16", in_ready, overflow, count);
      end
      in_data = 8'hFF;
      tick();
      in_strobe = 1'b0;
      n_checks++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         n_fail++;
         $display("FAIL ovf_drop: got ovf=%b cnt=%0d, want 1 16", overflow, count);
      end
   endtask

   task automatic test_full_push_pop();
      int base;
      bit ok;
      do_reset();
      ready_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         in_strobe = 1'b1; in_data = 8'(8'h80 + i);
         tick();
      end
      in_strobe = 1'b0;
      n_checks++;
      if (overflow !== 1'b0 || count !== 5'd16) begin
         n_fail++;
         $display("FAIL pp_fill: got ovf=%b cnt=%0d, want 0 16", overflow, count);
      end
      base = rx_q.size();
      in_strobe = 1'b1; in_data = 8'hEE; ready_en = 1'b1;
      tick();
      in_strobe = 1'b0;
      n_checks++;
      if (overflow !== 1'b1 || count !== 5'd15 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL pp_same_cycle: got ovf=%b cnt=%0d ready=%b, want 1 15 1", overflow, count, in_ready);
      end
      wait_rx(base + 16, 800, ok);
      repeat (30) tick();
      n_checks++;
      if (!ok || rx_q.size() - base !== 16) begin
         n_fail++;
         $display("FAIL pp_drain_count: got %0d bytes, want 16", rx_q.size() - base);
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (rx_q.size() <= base + i || rx_q[base + i] !== 8'(8'h80 + i)) begin
            n_fail++;
            $display("FAIL pp_order%0d: got %h, want %h", i,
                     (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx, 8'(8'h80 + i));
         end
      end
   endtask

   task automatic test_wrap();
      int base;
      int sent;
      int guard;
      bit ok;
      logic [7:0] exp_q[$];
      base = rx_q.size();
      ready_en = 1'b1;
      sent = 0;
      guard = 0;
      while (sent < 40 && guard < 2000) begin
         if (in_ready) begin
            in_strobe = 1'b1;
            in_data = 8'((sent * 37 + 5) & 8'hFF);
            exp_q.push_back(in_data);
            sent++;
         end else begin
            in_strobe = 1'b0;
         end
         tick();
         guard++;
      end
      in_strobe = 1'b0;
      wait_rx(base + 40, 1500, ok);
      n_checks++;
      if (!ok || sent != 40) begin
         n_fail++;
         $display("FAIL wrap_timeout: got sent=%0d rx=%0d, want 40 40", sent, rx_q.size() - base);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (rx_q.size() <= base + i || rx_q[base + i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL wrap_order%0d: got %h, want %h", i,
                     (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx, exp_q[i]);
         end
      end
      repeat (30) tick();
      n_checks++;
      if (count !== 5'd0 || rx_q.size() - base !== 40) begin
         n_fail++;
         $display("FAIL wrap_final: got cnt=%0d rx=%0d, want 0 40", count, rx_q.size() - base);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      int t;
      bit ok;
      ready_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_strobe = 1'b1; in_data = 8'(8'h31 + i);
         tick();
      end
      in_strobe = 1'b0;
      n_checks++;
      if (count !== 5'd5) begin
         n_fail++;
         $display("FAIL mid_count5: got %0d, want 5", count);
      end
      ready_en = 1'b1;
      t = 0;
      while (tx_strobe !== 1'b1 && t < 10) begin
         tick();
         t++;
      end
      repeat (3) tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if ({in_ready, overflow, count, tx_data, tx_strobe} !== {1'b1, 1'b0, 5'd0, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_reset_values: got ready=%b ovf=%b cnt=%0d data=%h stb=%b, want 1 0 0 00 0",
                  in_ready, overflow, count, tx_data, tx_strobe);
      end
      reset = 1'b0;
      tick();
      base = rx_q.size();
      in_strobe = 1'b1; in_data = 8'h5A;
      tick();
      in_data = 8'hA5;
      tick();
      in_strobe = 1'b0;
      wait_rx(base + 2, 400, ok);
      repeat (30) tick();
      n_checks++;
      if (!ok || rx_q.size() - base !== 2 || rx_q[base] !== 8'h5A || rx_q[base + 1] !== 8'hA5) begin
         n_fail++;
         $display("FAIL mid_after_reset: got n=%0d, want bytes 5A A5", rx_q.size() - base);
      end
   endtask

   task automatic test_crlf();
      int base;
      bit ok;
      logic [7:0] exp_q[$];
`ifdef UART_TX_FIFO_CRLF_EN
      exp_q = '{8'h41, 8'h0D, 8'h0A};
`else
      exp_q = '{8'h41, 8'h0A};
`endif
      base = rx_q.size();
      ready_en = 1'b1;
      in_strobe = 1'b1; in_data = 8'h41;
      tick();
      in_data = 8'h0A;
      tick();
      in_strobe = 1'b0;
      wait_rx(base + exp_q.size(), 400, ok);
      repeat (40) tick();
      n_checks++;
      if (!ok || rx_q.size() - base !== exp_q.size() || count !== 5'd0) begin
         n_fail++;
         $display("FAIL crlf_count: got n=%0d cnt=%0d, want n=%0d cnt=0",
                  rx_q.size() - base, count, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (rx_q.size() <= base + i || rx_q[base + i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL crlf_byte%0d: got %h, want %h", i,
                     (rx_q.size() > base + i) ? rx_q[base + i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      in_data   = 8'h00;
      in_strobe = 1'b0;
      ready_en  = 1'b0;
      #2;
      test_reset();
      test_abc();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_reset_mid();
      test_crlf();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
